// File: rtl/exec_arb_pkg.sv
// Shared constants for the logic issue arbiter: op codes, the immediate
// width and the bit of the op code that selects the immediate operand.
package exec_arb_pkg;

  localparam int IMM_W       = 21;
  localparam int IMM_SEL_BIT = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic [CTRL_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ANDI = 3'b100,
    OP_ORI  = 3'b101,
    OP_XORI = 3'b110
  } logic_op_e;

  // 011 and 111 are the only undefined encodings.
  function automatic logic op_defined(input logic [CTRL_W-1:0] c);
    return c[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer that
// moves to one past the granted requester only when advance is asserted.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d, gidx;
  logic [IDX_W:0]   idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      if (!found && req[idx[IDX_W-1:0]]) begin
        grant[idx[IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = IDX_W'(i);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/logic_issue_arbiter.sv
// Round-robin issue of bitwise logic ops from NUM_REQ requesters into a single
// result slot. Define LOGIC_ARB_PERF_EN to add the stall_cnt perf counter.
module logic_issue_arbiter
  import exec_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][CTRL_W-1:0]      req_ctrl,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_src1,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_src2,
  input  logic [NUM_REQ-1:0][IMM_W-1:0]       req_imm,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [ID_W-1:0]                     out_id,
  output logic [TAG_W-1:0]                    out_tag,
  output logic                                out_err
`ifdef LOGIC_ARB_PERF_EN
  ,output logic [15:0]                        stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_W-1:0]       id;
    logic [TAG_W-1:0]      tag;
    logic                  err;
  } result_t;

  result_t                res_q, res_d;
  logic                   out_valid_q;
  logic                   issue_ok, fire;
  logic [NUM_REQ-1:0]     arb_req, grant;

  logic [CTRL_W-1:0]      sel_ctrl;
  logic [DATA_WIDTH-1:0]  sel_src1, sel_src2, op2;
  logic [IMM_W-1:0]       sel_imm;
  logic [TAG_W-1:0]       sel_tag;
  logic [ID_W-1:0]        sel_id;

  // Slot is free or being drained this cycle; reset blocks every handshake.
  assign issue_ok = !out_valid_q || out_ready;
  assign arb_req  = (issue_ok && !reset) ? req_valid : '0;
  assign fire     = |grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (fire),
    .grant   (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_ctrl = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    sel_imm  = '0;
    sel_tag  = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_ctrl = req_ctrl[i];
        sel_src1 = req_src1[i];
        sel_src2 = req_src2[i];
        sel_imm  = req_imm[i];
        sel_tag  = req_tag[i];
        sel_id   = ID_W'(i);
      end
    end
  end

  assign op2 = sel_ctrl[IMM_SEL_BIT] ? DATA_WIDTH'(sel_imm) : sel_src2;

  always_comb begin
    res_d     = '0;
    res_d.id  = sel_id;
    res_d.tag = sel_tag;
    res_d.err = !op_defined(sel_ctrl);
    case (logic_op_e'(sel_ctrl))
      OP_AND, OP_ANDI: res_d.data = sel_src1 & op2;
      OP_OR,  OP_ORI:  res_d.data = sel_src1 | op2;
      OP_XOR, OP_XORI: res_d.data = sel_src1 ^ op2;
      default:         res_d.data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Outputs read as zero for the whole reset assertion, not only after the edge.
  assign out_valid = out_valid_q & ~reset;
  assign out_data  = reset ? '0 : res_q.data;
  assign out_id    = reset ? '0 : res_q.id;
  assign out_tag   = reset ? '0 : res_q.tag;
  assign out_err   = res_q.err & ~reset;

`ifdef LOGIC_ARB_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if ((|req_valid) && !fire && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_logic_issue_arbiter.sv
// Randomised + directed bench for logic_issue_arbiter with a queue scoreboard
// and a negedge monitor; a behavioural model predicts grants and results.
module tb_logic_issue_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0][2:0]      req_ctrl = '0;
  logic [N-1:0][DW-1:0]   req_src1 = '0;
  logic [N-1:0][DW-1:0]   req_src2 = '0;
  logic [N-1:0][20:0]     req_imm = '0;
  logic [N-1:0][TW-1:0]   req_tag = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DW-1:0]          out_data;
  logic [1:0]             out_id;
  logic [TW-1:0]          out_tag;
  logic                   out_err;
`ifdef LOGIC_ARB_PERF_EN
  logic [15:0]            stall_cnt;
`endif

  logic_issue_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_imm   (req_imm),
    .req_tag   (req_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_tag   (out_tag),
    .out_err   (out_err)
`ifdef LOGIC_ARB_PERF_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model state
  int   ptr = 0;
  bit   mvalid = 0;
  int   pend_g = -1;
  bit   pend_rdy = 0;
  int   last_g = -1;

  logic [N-1:0][2:0]    stg_ctrl = '0;
  logic [N-1:0][DW-1:0] stg_src1 = '0;
  logic [N-1:0][DW-1:0] stg_src2 = '0;
  logic [N-1:0][20:0]   stg_imm = '0;
  logic [N-1:0][TW-1:0] stg_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [2:0] c, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [20:0] im,
                                  input int id, input logic [TW-1:0] tg);
    exp_t e;
    logic [DW-1:0] opb;
    opb   = c[2] ? {11'b0, im} : b;
    e.id  = 2'(id);
    e.tag = tg;
    e.err = 1'b0;
    case (c)
      3'b000, 3'b100: e.data = a & opb;
      3'b001, 3'b101: e.data = a | opb;
      3'b010, 3'b110: e.data = a ^ opb;
      default: begin e.data = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock cycle: retire the model's previous decision, drive new inputs,
  // predict this cycle's grant and push its expected result.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic rst);
    int g;
    logic [N-1:0] eg;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      mvalid = 0;
      ptr    = 0;
    end else if (pend_g >= 0) begin
      ptr    = (pend_g + 1) % N;
      mvalid = 1;
    end else if (pend_rdy) begin
      mvalid = 0;
    end
    #1;
    req_ctrl = stg_ctrl; req_src1 = stg_src1; req_src2 = stg_src2;
    req_imm  = stg_imm;  req_tag  = stg_tag;
    req_valid = v; out_ready = rdy; reset = rst;
    #1;
    chk("out_valid", 64'(out_valid), 64'(rst ? 1'b0 : mvalid));
    g = -1;
    if (!rst && (!mvalid || rdy))
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    eg = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(eg));
    if (g >= 0)
      exp_q.push_back(ref_op(stg_ctrl[g], stg_src1[g], stg_src2[g], stg_imm[g], g, stg_tag[g]));
    pend_g   = g;
    pend_rdy = rdy;
    last_g   = g;
  endtask

  task automatic rand_stage();
    logic [31:0] r;
    for (int i = 0; i < N; i++) begin
      stg_ctrl[i] = 3'($urandom_range(0, 7));
      stg_src1[i] = $urandom();
      stg_src2[i] = $urandom();
      r = $urandom();
      stg_imm[i]  = r[20:0];
      stg_tag[i]  = 4'($urandom_range(0, 15));
    end
  endtask

  // Monitor: whenever a result is presented, compare against the queue head;
  // pop it only when the downstream accepts.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        chk("mon_data", 64'(out_data), 64'(exp_q[0].data));
        chk("mon_id",   64'(out_id),   64'(exp_q[0].id));
        chk("mon_tag",  64'(out_tag),  64'(exp_q[0].tag));
        chk("mon_err",  64'(out_err),  64'(exp_q[0].err));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    logic [N-1:0]  v;

    // Reset with requests pending: nothing accepted, outputs zero
    rand_stage();
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_id",    64'(out_id),    64'(0));
    chk("rst_tag",   64'(out_tag),   64'(0));
    chk("rst_err",   64'(out_err),   64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));

    // All requesters continuously valid: grants rotate 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b1, 1'b0);
      chk("rr_seq", 64'(last_g), 64'(i % N));
    end

    // AND from requester 0
    stg_ctrl[0] = 3'b000; stg_src1[0] = 32'hF0F0_F0F0; stg_src2[0] = 32'hFF00_FF00;
    stg_tag[0] = 4'd3;
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("and_data", 64'(out_data), 64'(32'hF000_F000));
    chk("and_id",   64'(out_id),   64'(0));
    chk("and_tag",  64'(out_tag),  64'(3));

    // XORI from requester 1 with a full-width immediate
    stg_ctrl[1] = 3'b110; stg_src1[1] = 32'h0000_00FF; stg_imm[1] = 21'h1F_FFFF;
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("xori_data", 64'(out_data), 64'(32'h001F_FF00));
    chk("xori_err",  64'(out_err),  64'(0));

    // Back-pressure with requester 2 pending
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    held = out_data;
    for (int i = 0; i < 2; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("stall_ready", 64'(req_ready), 64'(0));
      chk("stall_hold",  64'(out_data),  64'(held));
    end
    step(4'b0100, 1'b1, 1'b0);
    chk("drain_grant", 64'(last_g), 64'(2));
    step(4'b0000, 1'b0, 1'b0);
    chk("drain_id", 64'(out_id), 64'(2));

    // Reset while a result is held: result dropped, pointer back to 0
    step(4'hF, 1'b0, 1'b1);
    step(4'b1010, 1'b1, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_grant", 64'(last_g), 64'(1));

    // Undefined op from requester 3, then pointer wraps to 0
    stg_ctrl[3] = 3'b011; stg_src1[3] = 32'hFFFF_FFFF; stg_src2[3] = 32'hFFFF_FFFF;
    step(4'b1000, 1'b1, 1'b0);
    chk("undef_grant", 64'(last_g), 64'(3));
    step(4'b0000, 1'b1, 1'b0);
    chk("undef_data", 64'(out_data), 64'(0));
    chk("undef_err",  64'(out_err),  64'(1));
    chk("undef_id",   64'(out_id),   64'(3));
    step(4'hF, 1'b1, 1'b0);
    chk("wrap_grant", 64'(last_g), 64'(0));

    // Random traffic with back-pressure, undefined ops and occasional reset
    for (int i = 0; i < 600; i++) begin
      rand_stage();
      v = 4'($urandom_range(0, 15));
      step(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
